systolic_skew_feeder: RTL
=========================

// Module: systolic_skew_feeder
// PURPOSE
//  Sits directly upstream of systolic_array. It accepts one feature vector (ROWS lanes) per cycle
//  from the feature buffer over a valid/ready stream. It re-times the vector into the diagonal
//  wavefront the array needs: lane r is delayed r extra cycles. It then drains the skew and
//  signals tile completion.
//  Bubbles (no accepted vector) are driven as zero data with valid low.
// PARAMETERS
//  WIDTH  8   bits per feature element (matches array width)
//  ROWS   3   feature lanes = array rows; must be >= 1
//  CNT_W  16  width of accepted-vector counter
// PORTS
//  clk_in       in   1            single clock, rising edge
//  rst_in       in   1            synchronous, active-high reset
//  start_in     in   1            begin a tile; sampled only in IDLE
//  in_valid     in   1            upstream vector valid
//  in_ready     out  1            feeder can accept this cycle
//  in_data      in   ROWS*WIDTH   packed vector; lane r = bits [r*WIDTH +: WIDTH]
//  in_last      in   1            qualifies final vector of tile (meaningful only on accept)
//  feat_out     out  ROWS*WIDTH   skewed lanes to array feature_input2
//  feat_valid   out  ROWS         per-lane valid
//  busy         out  1            high in STREAM or DRAIN
//  done         out  1            one-cycle pulse when drain completes
//  vec_count    out  CNT_W        vectors accepted in current or last tile
// BEHAVIOUR
//  Reset (rst_in=1 at clk edge): state=IDLE; feat_out=0; feat_valid=0; in_ready=0; busy=0;
//   done=0; vec_count=0; all skew registers cleared. Reset mid-tile aborts it: no done pulse,
//   partial data discarded.
//  Accept = in_valid & in_ready. in_ready = (state==STREAM). It is a registered-state decode
//   with no combinational path from in_valid.
//  FSM:
//   IDLE   -> STREAM on start_in; vec_count cleared to 0 on that edge.
//   STREAM -> DRAIN on accept with in_last=1.
//   STREAM holds otherwise; upstream bubbles are allowed indefinitely.
//   DRAIN  -> IDLE after exactly ROWS-1 drain cycles; done=1 in the cycle state returns to IDLE.
//   ROWS==1: DRAIN lasts 0 cycles; STREAM goes to IDLE directly and done pulses the next cycle.
//  start_in outside IDLE is ignored.
//  start_in on the same edge done is asserted (state==IDLE) starts a new tile.
//  Skew: lane r passes through r+1 registers. A vector accepted on edge t gives
//   feat_out lane r = in_data lane r and feat_valid[r]=1 after edge t+1+r.
//  On cycles without accept, stage 0 of every lane loads data 0 with valid 0.
//   The diagonal therefore keeps its alignment across bubbles.
//  vec_count increments by 1 per accept, wraps modulo 2^CNT_W, and holds its value in IDLE.
//  feat_out lane r is 0 whenever feat_valid[r]=0. The array sees no stale data.
//  No downstream backpressure: the array consumes every cycle.
// STRUCTURE
//  Package sys_pkg: typedef state_e {IDLE, STREAM, DRAIN}; localparams DEF_WIDTH=8, DEF_ROWS=3.
//  Sub-module skew_line #(WIDTH, DELAY): DELAY-stage shift register of {valid,data}
//   with synchronous clear. It is instantiated ROWS times in a generate loop with DELAY=r+1.
//  Top level holds the FSM, the drain counter ($clog2(ROWS)+1 bits), vec_count and the
//   handshake logic.
// TESTING
//  1. Reset with ROWS=3, then start, then 3 back-to-back vectors {1,2,3},{4,5,6},{7,8,9} with last
//   on the third. Required: lane0 shows 1,4,7 on cycles t+1..t+3; lane1 shows 2,5,8 on t+2..t+4;
//   lane2 shows 3,6,9 on t+3..t+5. done pulses once; vec_count=3.
//  2. Same tile with in_valid low for 2 cycles between vectors 1 and 2. Required: each lane shows
//   a 2-cycle zero/valid-0 gap; relative lane skew stays exactly 1 cycle.
//  3. Pulse start_in during STREAM and DRAIN. Required: no effect; vec_count is not cleared.
//   in_ready stays 0 in DRAIN and IDLE even with in_valid=1.
//  4. Assert rst_in mid-STREAM after 2 accepts. Required: next cycle all outputs 0, state IDLE,
//   no done pulse, vec_count=0.
//  5. Assert start_in in the done cycle. Required: new tile enters STREAM next edge and
//   in_ready=1. Also run with ROWS=1: done follows the last-accept edge by one cycle.
//  6. CNT_W=4, stream 17 vectors. Required: vec_count=1 (wrap) and the data path is unaffected.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the systolic skew feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROWS  = 3;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// One lane of the skew: DELAY-stage shift register of {valid,data} with sync clear.
// Latency: DELAY cycles from i_vld/i_dat to o_vld/o_dat.
// Backpressure: none; shifts every cycle, data forced to zero when not valid.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DELAY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
);

    logic [DELAY-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DELAY];

    // Shift the lane one stage per cycle; stage 0 takes zero data on bubbles so stale values never leak
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int i = 0; i < DELAY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_dat[0] <= i_vld ? i_dat : '0;
            for (int i = 1; i < DELAY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_vld = r_vld[DELAY-1];
    assign o_dat = r_dat[DELAY-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Re-times accepted feature vectors into a diagonal wavefront (lane r delayed r extra cycles).
// Latency: lane r appears r+1 cycles after the accepting edge; done with the last lane's final element.
// Backpressure: in_ready is a pure state decode (high only in STREAM); no downstream backpressure.
module systolic_skew_feeder
    import sys_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROWS  = DEF_ROWS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic [ROWS*WIDTH-1:0]   feat_out,
    output logic [ROWS-1:0]         feat_valid,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        vec_count
);

    // Drain counter must hold ROWS-1; one spare bit keeps ROWS==1 legal.
    localparam int DW = $clog2(ROWS) + 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(ROWS - 1);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DW-1:0]     r_drain;
    logic [DW-1:0]     w_drain_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;

    assign in_ready  = (r_state == STREAM);
    assign w_accept  = in_valid & in_ready;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign vec_count = r_cnt;

    // FSM state, drain counter and registered done pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state: tile runs STREAM until the last accept, then drains ROWS-1 cycles so the skew empties
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_accept && in_last) begin
                    if (ROWS == 1) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                if (r_drain <= DRAIN_ONE) begin
                    w_state_nxt = IDLE;
                    w_drain_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain - DRAIN_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_drain_nxt = '0;
            end
        endcase
    end

    // Vector counter: cleared when a tile starts, bumps per accept, wraps naturally, holds in IDLE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && start_in) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Lane r gets r+1 stages; all lanes load together so bubbles keep the diagonal aligned
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        skew_line #(
            .WIDTH (WIDTH),
            .DELAY (r + 1)
        ) u_line (
            .i_clk (clk_in),
            .i_rst (rst_in),
            .i_vld (w_accept),
            .i_dat (in_data[r*WIDTH +: WIDTH]),
            .o_vld (feat_valid[r]),
            .o_dat (feat_out[r*WIDTH +: WIDTH])
        );
    end

endmodule
